// File: rtl/reg_dump_uart.sv
// Register-file dump engine: walks x0..x31 through the debug read port and
// streams each 32-bit word MSB byte first over a UART 8N1 line.
// Optional macro REG_DUMP_PC_EN appends a 33rd word carrying PC.
module reg_dump_uart #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] Debug_out,
  input  logic [31:0] PC,
  output logic [4:0]  Debug_Source_select,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef REG_DUMP_PC_EN
  localparam logic [5:0] LAST_WORD = 6'd32;
`else
  localparam logic [5:0] LAST_WORD = 6'd31;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START_BIT,
    DATA,
    STOP,
    FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          word_idx_q, word_idx_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [31:0]         word_q, word_d;
  logic                tx_q, tx_d;
  logic [7:0]          cur_byte;
  logic                baud_end;

`ifndef REG_DUMP_PC_EN
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    cur_byte = word_q[31:24];
    case (byte_cnt_q)
      2'd0: cur_byte = word_q[31:24];
      2'd1: cur_byte = word_q[23:16];
      2'd2: cur_byte = word_q[15:8];
      2'd3: cur_byte = word_q[7:0];
      default: cur_byte = word_q[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      word_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
    end
  end

  // tx_d is the line level for the state being entered, so tx is registered
  // and only ever changes on a bit boundary.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    word_d     = word_q;
    tx_d       = 1'b1;
    case (state_q)
      IDLE: begin
        word_idx_d = '0;
        byte_cnt_d = '0;
        bit_idx_d  = '0;
        baud_d     = '0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
`ifdef REG_DUMP_PC_EN
        word_d = (word_idx_q == LAST_WORD) ? PC : Debug_out;
`else
        word_d = Debug_out;
`endif
        byte_cnt_d = '0;
        baud_d     = '0;
        state_d    = START_BIT;
        tx_d       = 1'b0;
      end
      START_BIT: begin
        tx_d = 1'b0;
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = cur_byte[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        tx_d = cur_byte[bit_idx_q];
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_d];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (byte_cnt_q != 2'd3) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            state_d    = START_BIT;
            tx_d       = 1'b0;
          end else if (word_idx_q != LAST_WORD) begin
            word_idx_d = word_idx_q + 6'd1;
            state_d    = LOAD;
          end else begin
            state_d = FINISH;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      FINISH: begin
        word_idx_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE) && (state_q != FINISH);
  assign done = (state_q == FINISH);

  // Index 32 (PC word) drives select 0.
  assign Debug_Source_select = (busy && !word_idx_q[5]) ? word_idx_q[4:0] : 5'd0;

endmodule

// File: tb/tb_reg_dump_uart.sv
// Scoreboard bench for reg_dump_uart: expected bytes are queued on each start,
// a UART receiver process decodes tx and checks against the queue.
module tb_reg_dump_uart;

  localparam int unsigned CPB      = 4;
  localparam int unsigned WORD_CYC = 1 + 40 * CPB;
`ifdef REG_DUMP_PC_EN
  localparam int unsigned WORDS = 33;
`else
  localparam int unsigned WORDS = 32;
`endif
  localparam int unsigned BUSY_EXP = WORDS * WORD_CYC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dbg;
  logic [31:0] pc = 32'h0000_0040;
  logic [4:0]  sel;
  logic        tx, busy, done;

  int total = 0;
  int bad = 0;
  int unsigned rx_pops = 0;
  int unsigned done_cnt = 0;
  logic done_prev = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign dbg = {8'h11, 8'h22, 8'h33, 3'b000, sel};

  reg_dump_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .Debug_out(dbg),
    .PC(pc),
    .Debug_Source_select(sel),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] exp_sel(input int unsigned w);
    logic [31:0] wv;
    wv = w;
    return (w < 32) ? wv[4:0] : 5'd0;
  endfunction

  task automatic push_dump();
    logic [31:0] w32;
    for (int unsigned w = 0; w < 32; w++) begin
      w32 = w;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      exp_q.push_back(w32[7:0]);
    end
`ifdef REG_DUMP_PC_EN
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h40);
`endif
  endtask

  // UART receiver / scoreboard monitor: samples mid-bit, aborts on reset
  always begin
    @(negedge clk);
    if (reset && tx == 1'b0) begin
      logic [7:0] b;
      logic       ok;
      logic       stop_bit;
      b = '0;
      ok = 1'b1;
      stop_bit = 1'b0;
      for (int unsigned k = 1; k <= 9 * CPB + CPB / 2; k++) begin
        @(negedge clk);
        if (!reset) begin
          ok = 1'b0;
          break;
        end
        if (k >= CPB + CPB / 2 && (k - CPB / 2) % CPB == 0 && k < 9 * CPB)
          b[(k - CPB / 2) / CPB - 1] = tx;
        if (k == 9 * CPB + CPB / 2) stop_bit = tx;
      end
      if (ok) begin
        chk("stop_bit", {31'd0, stop_bit}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'd0, b}, 32'hFFFF_FFFF);
        end else begin
          chk("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
          rx_pops++;
        end
      end
    end
  end

  // done must be a single-cycle pulse
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      chk("done_width", {31'd0, done_prev}, 32'd0);
    end
    done_prev <= done;
  end

  task automatic wait_done(input int unsigned init, output int unsigned nbusy,
                           output int unsigned gap, output logic got);
    logic seen;
    nbusy = init;
    gap = 0;
    got = 1'b0;
    seen = (init != 0);
    for (int unsigned i = 0; i < 3 * BUSY_EXP; i++) begin
      @(negedge clk);
      if (done) begin
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        got = 1'b1;
        break;
      end
      if (busy) begin
        seen = 1'b1;
        if (nbusy % WORD_CYC == 0)
          chk("sel_at_load", {27'd0, sel}, {27'd0, exp_sel(nbusy / WORD_CYC)});
        nbusy++;
      end else if (!seen) begin
        gap++;
      end
    end
  endtask

  task automatic bit_timing();
    logic found;
    logic [9:0] frame;
    frame = {1'b1, 8'h11, 1'b0};
    found = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    chk("first_start_seen", {31'd0, found}, 32'd1);
    if (found) begin
      for (int unsigned j = 0; j < 10 * CPB; j++) begin
        if (j != 0) @(negedge clk);
        chk("bit_timing", {31'd0, tx}, {31'd0, frame[j / CPB]});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nbusy, gap, pops0, dcnt0;
    logic got;

    // reset held low while start toggles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = (i % 2 == 0);
      #1;
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sel", {27'd0, sel}, 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, busy}, 32'd0);
    end

    // single dump with bit-timing check
    push_dump();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", {31'd0, busy}, 32'd1);
    chk("load_tx", {31'd0, tx}, 32'd1);
    fork
      wait_done(1, nbusy, gap, got);
      bit_timing();
    join
    chk("dump1_done", {31'd0, got}, 32'd1);
    chk("dump1_busy_cycles", nbusy, BUSY_EXP);
    chk("dump1_queue_empty", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);

    // start held high: back-to-back dumps, one per IDLE entry
    push_dump();
    push_dump();
    start = 1'b1;
    @(negedge clk);
    chk("held_load_busy", {31'd0, busy}, 32'd1);
    wait_done(1, nbusy, gap, got);
    chk("held1_done", {31'd0, got}, 32'd1);
    chk("held1_busy_cycles", nbusy, BUSY_EXP);
    wait_done(0, nbusy, gap, got);
    start = 1'b0;
    chk("held2_done", {31'd0, got}, 32'd1);
    chk("held2_busy_cycles", nbusy, BUSY_EXP);
    chk("held_restart_gap_le1", {31'd0, (gap <= 1)}, 32'd1);
    chk("held_queue_empty", exp_q.size(), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("no_extra_dump", {31'd0, busy}, 32'd0);
    end

    // reset during second byte of word 5
    push_dump();
    pops0 = rx_pops;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5 * WORD_CYC + 1 + 10 * CPB + 5 * CPB) @(negedge clk);
    dcnt0 = done_cnt;
    reset = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_sel", {27'd0, sel}, 32'd0);
    chk("midrst_bytes_rx", rx_pops - pops0, 32'd21);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", done_cnt - dcnt0, 32'd0);
    chk("midrst_stays_idle", {31'd0, busy}, 32'd0);

    // fresh dump restarts at x0
    push_dump();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_sel", {27'd0, sel}, 32'd0);
    wait_done(1, nbusy, gap, got);
    chk("restart_done", {31'd0, got}, 32'd1);
    chk("restart_busy_cycles", nbusy, BUSY_EXP);
    chk("restart_queue_empty", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
